// File: rtl/pcecd_scsi_pkg.sv
// Shared definitions for the PC Engine CD SCSI target: bus phases, $1800 bit layout,
// status codes and CDB length decode.
package pcecd_scsi_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PhBusFree   = 3'd0;
  localparam phase_t PhCommand   = 3'd1;
  localparam phase_t PhExecute   = 3'd2;
  localparam phase_t PhDataIn    = 3'd3;
  localparam phase_t PhStatus    = 3'd4;
  localparam phase_t PhMessageIn = 3'd5;

  // Bit positions of the bus signals in the $1800 status register.
  localparam int unsigned BSY = 7;
  localparam int unsigned REQ = 6;
  localparam int unsigned MSG = 5;
  localparam int unsigned CD  = 4;
  localparam int unsigned IO  = 3;

  localparam logic [7:0] STATUS_GOOD  = 8'h00;
  localparam logic [7:0] STATUS_CHECK = 8'h02;

  // CDB length from the opcode group field (opcode[7:5]).
  function automatic int unsigned cdb_len(input logic [2:0] group);
    case (group)
      3'd0:       return 6;
      3'd1, 3'd2: return 10;
      3'd5:       return 12;
      default:    return 6;
    endcase
  endfunction

endpackage

// File: rtl/pcecd_scsi_target_fifo.sv
// Show-ahead synchronous byte FIFO holding drive sector data for the DATA_IN phase.
module pcecd_byte_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // Count never exceeds Depth, so its top bit alone marks full.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pcecd_scsi_target.sv
// Target-side SCSI bus-phase engine: selection, CDB capture, DATA_IN streaming from the
// sector FIFO, STATUS and MESSAGE_IN, with drive IRQ events.
module pcecd_scsi_target
  import pcecd_scsi_pkg::*;
#(
  parameter int unsigned CMD_AW  = 4,
  parameter int unsigned FIFO_AW = 11,
  parameter int unsigned DW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scsi_sel_i,
  input  logic              scsi_ack_i,
  input  logic              scsi_rst_i,
  input  logic [DW-1:0]     db_in_i,
  output logic              bsy_o,
  output logic              req_o,
  output logic              msg_o,
  output logic              cd_o,
  output logic              io_o,
  output logic [DW-1:0]     db_out_o,
  output logic              cmd_valid_o,
  output logic [CMD_AW-1:0] cmd_len_o,
  input  logic [CMD_AW-1:0] cmd_rd_addr_i,
  output logic [DW-1:0]     cmd_rd_data_o,
  input  logic              xfer_start_i,
  input  logic              data_wr_i,
  input  logic [DW-1:0]     data_in_i,
  output logic              data_full_o,
  output logic              overflow_o,
  input  logic              status_valid_i,
  input  logic [DW-1:0]     status_byte_i,
  input  logic [DW-1:0]     message_byte_i,
  output logic              irq_ready_o,
  output logic              irq_done_o
);

  localparam int unsigned       CmdDepth = 2 ** CMD_AW;
  localparam logic [CMD_AW-1:0] PosMax   = '1;

  phase_t            state_q, state_d;
  logic              req_q, req_d;
  logic [DW-1:0]     db_out_q, db_out_d;
  logic [CMD_AW-1:0] pos_q, pos_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CMD_AW-1:0] cmd_len_q, cmd_len_d;
  logic              pending_q, pending_d;
  logic [DW-1:0]     status_q, status_d;
  logic [DW-1:0]     message_q, message_d;
  logic              overflow_q, overflow_d;
  logic              irq_done_q, irq_done_d;
  logic [DW-1:0]     cdb_q [CmdDepth];
  logic              cdb_we;

  logic [DW-1:0]    fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;

  pcecd_byte_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (scsi_rst_i),
    .push_i  (data_wr_i),
    .wdata_i (data_in_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    db_out_d    = db_out_q;
    pos_d       = pos_q;
    cmd_valid_d = 1'b0;
    cmd_len_d   = cmd_len_q;
    pending_d   = pending_q;
    status_d    = status_q;
    message_d   = message_q;
    overflow_d  = overflow_q | (data_wr_i & fifo_full);
    irq_done_d  = 1'b0;
    cdb_we      = 1'b0;
    fifo_pop    = 1'b0;

    if (scsi_rst_i) begin
      state_d    = PhBusFree;
      req_d      = 1'b0;
      db_out_d   = '0;
      pos_d      = '0;
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        PhBusFree: begin
          if (scsi_sel_i) begin
            state_d   = PhCommand;
            req_d     = 1'b1;
            pos_d     = '0;
            pending_d = 1'b0;
          end
        end
        PhCommand: begin
          if (req_q && scsi_ack_i) begin
            cdb_we = 1'b1;
            pos_d  = (pos_q == PosMax) ? pos_q : pos_q + 1'b1;
            req_d  = 1'b0;
          end else if (!req_q && !scsi_ack_i && pos_q != '0) begin
            // Length is re-decoded from the stored opcode after every byte.
            if (32'(pos_q) == cdb_len(cdb_q[0][DW-1 -: 3])) begin
              cmd_valid_d = 1'b1;
              cmd_len_d   = pos_q;
              state_d     = PhExecute;
            end else begin
              req_d = 1'b1;
            end
          end
        end
        PhExecute: begin
          if (xfer_start_i) begin
            state_d = PhDataIn;
            if (status_valid_i) begin
              status_d  = status_byte_i;
              message_d = message_byte_i;
              pending_d = 1'b1;
            end
          end else if (status_valid_i) begin
            state_d   = PhStatus;
            status_d  = status_byte_i;
            message_d = message_byte_i;
            db_out_d  = status_byte_i;
            req_d     = 1'b1;
          end
        end
        PhDataIn: begin
          if (status_valid_i) begin
            status_d  = status_byte_i;
            message_d = message_byte_i;
            pending_d = 1'b1;
          end
          if (req_q && scsi_ack_i) begin
            req_d = 1'b0;
          end else if (!req_q && !scsi_ack_i) begin
            if (!fifo_empty) begin
              db_out_d = fifo_head;
              fifo_pop = 1'b1;
              req_d    = 1'b1;
            end else if (pending_q) begin
              state_d  = PhStatus;
              db_out_d = status_q;
              req_d    = 1'b1;
            end
          end
        end
        PhStatus: begin
          if (req_q && scsi_ack_i) begin
            req_d = 1'b0;
          end else if (!req_q && !scsi_ack_i) begin
            state_d  = PhMessageIn;
            db_out_d = message_q;
            req_d    = 1'b1;
          end
        end
        PhMessageIn: begin
          if (req_q && scsi_ack_i) begin
            req_d = 1'b0;
          end else if (!req_q && !scsi_ack_i) begin
            state_d    = PhBusFree;
            db_out_d   = '0;
            pending_d  = 1'b0;
            irq_done_d = 1'b1;
          end
        end
        default: begin
          state_d = PhBusFree;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PhBusFree;
      req_q       <= 1'b0;
      db_out_q    <= '0;
      pos_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_len_q   <= '0;
      pending_q   <= 1'b0;
      status_q    <= '0;
      message_q   <= '0;
      overflow_q  <= 1'b0;
      irq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      db_out_q    <= db_out_d;
      pos_q       <= pos_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_len_q   <= cmd_len_d;
      pending_q   <= pending_d;
      status_q    <= status_d;
      message_q   <= message_d;
      overflow_q  <= overflow_d;
      irq_done_q  <= irq_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CmdDepth; i++) cdb_q[i] <= '0;
    end else if (cdb_we) begin
      cdb_q[pos_q] <= db_in_i;
    end
  end

  assign bsy_o         = (state_q != PhBusFree);
  assign msg_o         = (state_q == PhMessageIn);
  assign cd_o          = (state_q == PhCommand) || (state_q == PhExecute) ||
                         (state_q == PhStatus) || (state_q == PhMessageIn);
  assign io_o          = (state_q == PhDataIn) || (state_q == PhStatus) ||
                         (state_q == PhMessageIn);
  assign req_o         = req_q;
  assign db_out_o      = db_out_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_len_o     = cmd_len_q;
  assign cmd_rd_data_o = cdb_q[cmd_rd_addr_i];
  assign data_full_o   = fifo_full;
  assign overflow_o    = overflow_q;
  assign irq_ready_o   = (state_q == PhDataIn) && (fifo_count == '0) && !pending_q;
  assign irq_done_o    = irq_done_q;

endmodule

// File: doc/pcecd_scsi_target.md
# pcecd_scsi_target

Parametrised SCSI target-side bus-phase engine for the PC Engine CD interface. It sits between the CPU register file ($1800-$180F decode) and the CD drive model. It runs the full REQ/ACK protocol through selection, command, data-in, status and message-in phases. It collects variable-length CDBs, streams drive sector data through an internal FIFO, and raises drive IRQ events.

## Interface
- CMD_AW, 4: command buffer address width; depth 2**CMD_AW, must be >= 12
- FIFO_AW, 11: data-in FIFO address width (2048 B = one sector by default)
- DW, 8: data bus width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- scsi_sel  in  1  initiator SEL
- scsi_ack  in  1  initiator ACK
- scsi_rst  in  1  initiator RST, level
- db_in  in  DW  initiator-driven data bus ($1801 write)
- bsy, req, msg, cd, io  out  1 each  target bus signals
- db_out  out  DW  target-driven data bus ($1801 read)
- cmd_valid  out  1  one-cycle pulse: full CDB captured
- cmd_len  out  CMD_AW  captured CDB length
- cmd_rd_addr  in  CMD_AW  CDB read index
- cmd_rd_data  out  DW  CDB byte, combinational read
- xfer_start  in  1  drive requests DATA_IN phase
- data_wr  in  1  push sector byte
- data_in  in  DW  sector byte
- data_full  out  1  FIFO full
- overflow  out  1  sticky: push while full, cleared by reset/scsi_rst
- status_valid  in  1  drive supplies final status
- status_byte, message_byte  in  DW  latched on status_valid
- irq_ready  out  1  level: in DATA_IN, FIFO empty, status not yet latched
- irq_done  out  1  one-cycle pulse on MESSAGE_IN -> BUS_FREE

## Operation
- States: BUS_FREE, COMMAND, EXECUTE, DATA_IN, STATUS, MESSAGE_IN.
- Phase signals, as {bsy,msg,cd,io}:
  - BUS_FREE 0000
  - COMMAND 1010
  - EXECUTE 1010 with req=0
  - DATA_IN 1001
  - STATUS 1011
  - MESSAGE_IN 1111
- BUS_FREE: scsi_sel=1 -> COMMAND. On entry: req=1, pos=0.
- COMMAND:
  - req&&ack: buf[pos]<=db_in, pos++, req<=0.
  - !req&&!ack with pos>0:
    - pos==len: cmd_valid pulse, cmd_len<=pos, go to EXECUTE.
    - otherwise req<=1.
  - len is decoded from buf[0][7:5]: 0 -> 6; 1 or 2 -> 10; 5 -> 12; any other value -> 6.
  - pos saturates at 2**CMD_AW-1.
- EXECUTE:
  - xfer_start -> DATA_IN.
  - status_valid -> STATUS.
  - Both in the same cycle -> DATA_IN, with status latched as pending.
- DATA_IN:
  - !req&&!ack&&FIFO non-empty: db_out<=head, pop, req<=1.
  - req&&ack: req<=0.
  - status_valid latches status/message and sets pending.
  - !req&&!ack&&FIFO empty&&pending -> STATUS.
- STATUS:
  - On entry: db_out=status_byte, req=1.
  - req&&ack: req<=0.
  - !req&&!ack: go to MESSAGE_IN with db_out=message_byte, req=1.
- MESSAGE_IN:
  - req&&ack: req<=0.
  - !req&&!ack: go to BUS_FREE and pulse irq_done.
- FIFO write side:
  - data_wr accepted in any state unless full.
  - A full-FIFO write is dropped and sets overflow.
  - Simultaneous push and pop: count unchanged.
- scsi_rst, any state: next cycle BUS_FREE, all bus outputs 0, FIFO flushed, pos=0, pending=0, overflow=0, no irq_done pulse. scsi_rst has priority over every other input.

## Timing
- All outputs are registered except cmd_rd_data.
- Reset values: bsy=req=msg=cd=io=0, db_out=0, cmd_valid=0, cmd_len=0, data_full=0, overflow=0, irq_ready=0, irq_done=0.
- scsi_sel to bsy=1, req=1: 1 cycle.
- ack=1 seen -> req=0 on the next edge.
- ack=0 seen -> next req=1 (or phase change) on the next edge.
- In DATA_IN, db_out is valid in the same cycle req rises.
- Last CDB byte: ack deassertion -> cmd_valid 1 cycle later.
- reset mid-transfer behaves identically to scsi_rst, and also clears the CDB buffer contents to 0.

## Structure
- Package pcecd_scsi_pkg holds:
  - the phase enum
  - signal bit positions BSY=7, REQ=6, MSG=5, CD=4, IO=3 (the $1800 layout)
  - STATUS_GOOD=8'h00 and STATUS_CHECK=8'h02
  - the CDB group-length function
- Sub-module pcecd_byte_fifo: parametrised DW x 2**FIFO_AW synchronous FIFO with show-ahead head, count, full/empty, and flush.

## Test plan
- Selection + 6-byte CDB 08 00 00 10 01 00:
  - cmd_valid pulses once, cmd_len=6, cmd_rd_data[3]=8'h10.
  - State ends in EXECUTE with bsy=1, cd=1, req=0.
- 10-byte CDB, opcode 8'h28: no cmd_valid after byte 6; cmd_valid after byte 10, cmd_len=10.
- xfer_start, push 4 bytes A0..A3, then status_valid with status 00 and message 00:
  - Initiator reads A0..A3 in order via the REQ/ACK handshake.
  - Then STATUS with db_out=00, then MESSAGE_IN, then BUS_FREE.
  - irq_done pulses once.
- Fill FIFO to 2048, push one more: data_full=1, overflow=1, the 2048 stored bytes read back intact.
- scsi_rst asserted mid-DATA_IN with 100 bytes queued: next cycle all bus signals 0, FIFO empty, overflow=0.
- xfer_start and status_valid in the same EXECUTE cycle with an empty FIFO: DATA_IN entered, irq_ready=0, then STATUS with no req in DATA_IN.
